// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage. Reads the current PC, fetches the instruction
// over a req/ack handshake, and buffers {pc, instr} pairs in a small FIFO
// for decode. It owns the PC register's write port. A branch or jump redirect
// arrives as flush.
//
// Ports:
//   clk, res                  clock and synchronous active-high reset
//   pc_in                     current PC register value
//   pc_write, pc_next         PC register write enable / next value (comb)
//   imem_req, imem_addr       level request, address held until ack
//   imem_ack, imem_rdata      one-cycle response strobe with data
//   if_valid, if_ready        FIFO head handshake toward decode
//   if_instr, if_pc           FIFO head instruction and its address
//   flush, flush_target       redirect: drop everything, new PC
//   if_misaligned             head entry was a misaligned-PC NOP
//                             (only with FETCH_MISALIGN_CHECK_EN)
//
// Build option: define FETCH_MISALIGN_CHECK_EN to turn a misaligned PC
// into a NOP entry flagged with if_misaligned, instead of fetching it.
// Fetch then halts until the next flush.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] pc_in,
  output logic        pc_write,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        flush,
  input  logic [31:0] flush_target
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        if_misaligned
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2} state_t;

  state_t             state;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        mem_pc    [FIFO_DEPTH];
  logic [31:0]        mem_instr [FIFO_DEPTH];

  logic               pop, push, has_room, launch;
  logic [31:0]        push_pc, push_instr;
  logic               post_reset;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic               mem_mis [FIFO_DEPTH];
  logic               push_mis;
  logic               mis_halt;
`endif

  // Room is judged after this cycle's pop. Only one request can be in
  // flight, and the count only falls while it is outstanding, so a request
  // launched with room always finds a free slot when its ack arrives.
  assign pop      = if_valid && if_ready;
  assign has_room = (cnt < CNT_W'(FIFO_DEPTH)) || pop;

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    push       = 1'b0;
    push_pc    = imem_addr;
    push_instr = imem_rdata;
    launch     = 1'b0;
    pc_write   = 1'b0;
    pc_next    = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
    push_mis   = 1'b0;
`endif
    if (!res) begin
      if (flush) begin
        // A redirect overrides any push, pop or ack in the same cycle.
        pc_write = 1'b1;
        pc_next  = flush_target;
      end else begin
        case (state)
          IDLE: begin
`ifdef FETCH_MISALIGN_CHECK_EN
            if (pc_in[1:0] != 2'b00) begin
              if (!mis_halt && has_room) begin
                push       = 1'b1;
                push_pc    = pc_in;
                push_instr = NOP;
                push_mis   = 1'b1;
              end
            end else
`endif
            if (has_room) launch = 1'b1;
          end
          REQ: begin
            if (imem_ack) begin
              push     = 1'b1;
              pc_write = 1'b1;
              pc_next  = imem_addr + 32'd4;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: all state is updated with non-blocking assignments. Every
  // register then samples the values from before the edge, no matter how
  // the blocks are ordered.
  always_ff @(posedge clk) begin
    if (res) begin
      state      <= IDLE;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      post_reset <= 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_halt   <= 1'b0;
`endif
    end else begin
      if (launch || flush) post_reset <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (flush)         mis_halt <= 1'b0;
      else if (push_mis) mis_halt <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (launch) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc_in;
          end
        end
        REQ: begin
          // An ack always retires the request. Only a flush with no ack
          // leaves a stale request to drain.
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // A flush here keeps draining. The ack still ends the stale
          // request; otherwise the stage would wait forever.
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: the storage has no reset. The count alone decides validity, and
  // the head outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= push_pc;
      mem_instr[wr_ptr] <= push_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
      mem_mis[wr_ptr]   <= push_mis;
`endif
    end
  end

  assign if_valid = (cnt != '0);
  assign if_instr = if_valid ? mem_instr[rd_ptr] : '0;
  assign if_pc    = if_valid ? mem_pc[rd_ptr]    : '0;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign if_misaligned = if_valid ? mem_mis[rd_ptr] : 1'b0;
`endif

  // The PC register must come out of reset at RESET_PC. The first fetch
  // launched after reset, before any redirect, exposes that value.
  first_fetch_pc: assert property (@(posedge clk) disable iff (res)
    (launch && post_reset) |-> (pc_in == RESET_PC));

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Drives if_fetch_unit with a PC register and an instruction memory that
// answers after a chosen latency. A transaction-level model tracks the next
// expected fetch PC and a queue of the instructions decode should see.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } entry_t;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [31:0] pc_in;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush = 1'b0;
  logic [31:0] flush_target = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        if_misaligned;
`endif

  always #5 clk = ~clk;

  // PC register environment
  logic [31:0] pc_reg;
  always @(posedge clk) begin
    if (res)           pc_reg <= RST_PC;
    else if (pc_write) pc_reg <= pc_next;
  end
  assign pc_in = pc_reg;

  if_fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .res          (res),
    .pc_in        (pc_in),
    .pc_write     (pc_write),
    .pc_next      (pc_next),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .flush        (flush),
    .flush_target (flush_target)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .if_misaligned(if_misaligned)
`endif
  );

  int tests = 0;
  int fails = 0;

  // reference model state
  entry_t      exp_q[$];
  logic [31:0] exp_next = RST_PC;
  bit          pending = 1'b0;
  bit          dropped = 1'b0;
  bit          mis_halt_m = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] req_addr = '0;
  int          new_reqs = 0;
  logic [31:0] last_new_addr = '0;

  // stimulus knobs
  int          ready_mode = 1;   // 0 random, 1 hold low, 2 hold high
  int          p_flush = 0;      // random flush percentage
  int          lat_fixed = 2;    // 0 = random latency 1..3
  bit          force_flush = 1'b0;
  logic [31:0] force_target = '0;
  bit          flush_on_ack = 1'b0;
  logic [31:0] foa_target = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: respond as memory, drive inputs, check, advance model.
  task automatic step();
    bit          ack_real, exp_pw, pop;
    logic [31:0] exp_pn;
    int          occ;
    entry_t      e;
    @(negedge clk);
    imem_ack = 1'b0;
    if (pending) begin
      check("req_held", imem_req, 1);
      check("addr_stable", imem_addr, req_addr);
      if (wait_cnt > 0) wait_cnt--;
      imem_ack = (wait_cnt == 0);
    end else if (imem_req) begin
      check("req_addr", imem_addr, exp_next);
      pending       = 1'b1;
      dropped       = 1'b0;
      req_addr      = imem_addr;
      last_new_addr = imem_addr;
      new_reqs++;
      wait_cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
    end
    ack_real   = imem_ack && pending;
    imem_rdata = ack_real ? mem_word(req_addr) : $urandom;
    if_ready   = (ready_mode == 1) ? 1'b0 : (ready_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
    flush        = 1'b0;
    flush_target = $urandom & 32'hFFFF_FFFC;
    if (force_flush) begin
      flush = 1'b1; flush_target = force_target; force_flush = 1'b0;
    end else if (flush_on_ack && ack_real) begin
      flush = 1'b1; flush_target = foa_target; flush_on_ack = 1'b0;
    end else if (int'($urandom_range(0, 99)) < p_flush) begin
      flush = 1'b1;
    end
    #1;
    exp_pw = flush || (ack_real && !dropped);
    exp_pn = flush ? flush_target : req_addr + 32'd4;
    check("pc_write", pc_write, exp_pw);
    if (exp_pw) check("pc_next", pc_next, exp_pn);
    check("if_valid", if_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("if_pc", if_pc, exp_q[0].pc);
      check("if_instr", if_instr, exp_q[0].instr);
`ifdef FETCH_MISALIGN_CHECK_EN
      check("if_misaligned", if_misaligned, exp_q[0].mis);
`endif
    end
    pop = (exp_q.size() != 0) && if_ready && !flush;
    occ = exp_q.size() - int'(pop);
    if (flush) begin
      exp_q.delete();
      exp_next   = flush_target;
      mis_halt_m = 1'b0;
      if (pending) begin
        if (imem_ack) pending = 1'b0;
        else          dropped = 1'b1;
      end
    end else begin
      if (pop) void'(exp_q.pop_front());
`ifdef FETCH_MISALIGN_CHECK_EN
      if (!pending && exp_next[1:0] != 2'b00 && !mis_halt_m && occ < int'(DEPTH)) begin
        e.pc = exp_next; e.instr = NOP; e.mis = 1'b1;
        exp_q.push_back(e);
        mis_halt_m = 1'b1;
      end
`endif
      if (ack_real) begin
        if (!dropped) begin
          e.pc = req_addr; e.instr = mem_word(req_addr); e.mis = 1'b0;
          exp_q.push_back(e);
          exp_next = req_addr + 32'd4;
        end
        pending = 1'b0;
      end
    end
    check("occupancy", exp_q.size() <= int'(DEPTH), 1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_req(input int max);
    int start;
    start = new_reqs;
    for (int i = 0; i < max && new_reqs == start; i++) step();
    check("req_timeout", new_reqs != start, 1);
  endtask

  // Reset for two edges. With late_ack, an ack hits the first edge after
  // res falls, while no request is outstanding.
  task automatic do_reset(input bit late_ack);
    @(negedge clk);
    res = 1'b1; imem_ack = 1'b0; flush = 1'b0; if_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", if_valid, 0);
    check("rst_instr", if_instr, 0);
    check("rst_pc", if_pc, 0);
    check("rst_pc_write", pc_write, 0);
    check("rst_pc_next", pc_next, 0);
    res = 1'b0;
    exp_q.delete();
    pending = 1'b0; dropped = 1'b0; mis_halt_m = 1'b0; exp_next = RST_PC;
    if (late_ack) begin
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      #1;
      check("late_ack_pc_write", pc_write, 0);
    end
  endtask

  initial begin
    int base;

    // 1: first fetch from reset, ack two cycles after the request
    do_reset(1'b0);
    ready_mode = 1; lat_fixed = 2; p_flush = 0;
    wait_req(10);
    check("t1_addr", last_new_addr, 32'h0);
    run(3);
    check("t1_valid", if_valid, 1);
    check("t1_instr", if_instr, 32'h0050_0093);
    check("t1_pc", if_pc, 32'h0);
    check("t1_pc_reg", pc_in, 32'h4);

    // 2: decode stalled; only two entries fit, a pop frees room for 0x108
    force_flush = 1'b1; force_target = 32'h100;
    run(1);
    base = new_reqs;
    run(30);
    check("t2_reqs", new_reqs - base, 2);
    check("t2_no_req", imem_req, 0);
    check("t2_head", if_pc, 32'h100);
    ready_mode = 2; run(1); ready_mode = 1;
    wait_req(10);
    check("t2_next_addr", last_new_addr, 32'h108);
    check("t2_head_after_pop", if_pc, 32'h104);

    // 3: flush while a request to 0x10 is outstanding
    ready_mode = 2; lat_fixed = 4;
    force_flush = 1'b1; force_target = 32'h10;
    wait_req(20);
    check("t3_req_addr", last_new_addr, 32'h10);
    force_flush = 1'b1; force_target = 32'h200;
    ready_mode = 1;
    run(1);
    run(1);
    check("t3_valid", if_valid, 0);
    check("t3_req_kept", imem_req, 1);
    check("t3_addr_kept", imem_addr, 32'h10);
    wait_req(20);
    check("t3_redirect_addr", last_new_addr, 32'h200);

    // 4: flush in the same cycle as the ack of 0x200
    lat_fixed = 2;
    flush_on_ack = 1'b1; foa_target = 32'h400;
    wait_req(20);
    check("t4_redirect_addr", last_new_addr, 32'h400);
    check("t4_valid", if_valid, 0);

    // address wrap at the top of the address space
    ready_mode = 2;
    force_flush = 1'b1; force_target = 32'hFFFF_FFFC;
    wait_req(20);
    check("wrap_addr", last_new_addr, 32'hFFFF_FFFC);
    wait_req(20);
    check("wrap_next", last_new_addr, 32'h0);

    // 5: reset mid-request, then a late ack just after reset
    ready_mode = 1; lat_fixed = 8;
    wait_req(20);
    run(2);
    do_reset(1'b1);
    wait_req(10);
    check("t5_first_addr", last_new_addr, RST_PC);
    check("t5_valid", if_valid, 0);

`ifdef FETCH_MISALIGN_CHECK_EN
    // misaligned PC turns into a flagged NOP and halts fetch
    lat_fixed = 2;
    run(12);
    force_flush = 1'b1; force_target = 32'h102;
    run(6);
    base = new_reqs;
    run(6);
    check("mis_no_new_req", new_reqs - base, 0);
    check("mis_req", imem_req, 0);
    check("mis_valid", if_valid, 1);
    check("mis_flag", if_misaligned, 1);
    check("mis_instr", if_instr, NOP);
    check("mis_pc", if_pc, 32'h102);
    check("mis_pc_write", pc_write, 0);
    force_flush = 1'b1; force_target = 32'h500;
    run(4);
`endif

    // random traffic
    ready_mode = 0; lat_fixed = 0; p_flush = 4;
    run(3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
